// File: rtl/stream_test_pkg.sv
// Shared constants and state encoding for the SDRAM stream test.
// The write-side generator and the read-back checker both import this package.
package stream_test_pkg;

  localparam int unsigned HALF_W = 16;
  localparam int unsigned WORD_W = 2 * HALF_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/cnt_stream_gen_t2.sv
// Stream source: emits 32-bit counter words as high/low 16-bit beats with backpressure,
// stop-at-word-boundary and single-shot error injection.
module cnt_stream_gen_t2 #(
  parameter int unsigned HALF_W = stream_test_pkg::HALF_W,
  parameter int unsigned WORD_W = stream_test_pkg::WORD_W,
  parameter int unsigned LEN    = 1024,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [WORD_W-1:0] seed,
  input  logic              full,
  input  logic              inject_err,
  output logic [HALF_W-1:0] data,
  output logic              wren,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  words_sent
);

  import stream_test_pkg::*;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   value_q, value_d;
  logic [CNT_W-1:0]    words_q, words_d;
  logic [HALF_W-1:0]   data_q, data_d;
  logic                wren_q, wren_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_pend_q, err_pend_d;
  logic                stop_pend_q, stop_pend_d;
  logic                len_hit;
  logic                end_run;

  assign len_hit = (LEN != 0) && (words_q == CNT_W'(LEN));
  assign end_run = stop || stop_pend_q || len_hit;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    words_d     = words_q;
    data_d      = data_q;
    wren_d      = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_pend_d  = err_pend_q;
    stop_pend_d = stop_pend_q;

    // Stop requests arriving mid-word are remembered until the next high-half slot.
    if (busy_q && stop) begin
      stop_pend_d = 1'b1;
    end
    if ((state_q == HI || state_q == LO) && inject_err) begin
      err_pend_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (start) begin
          value_d    = seed;
          words_d    = '0;
          busy_d     = 1'b1;
          err_pend_d = 1'b0;
          state_d    = HI;
        end
      end
      HI: begin
        if (end_run) begin
          state_d = DONE;
        end else if (!full) begin
          data_d  = value_q[WORD_W-1 -: HALF_W];
          wren_d  = 1'b1;
          state_d = LO;
        end
      end
      LO: begin
        if (!full) begin
          data_d     = value_q[HALF_W-1:0];
          wren_d     = 1'b1;
          words_d    = words_q + CNT_W'(1);
          value_d    = value_q + (err_pend_q ? WORD_W'(2) : WORD_W'(1));
          err_pend_d = inject_err;
          state_d    = HI;
        end
      end
      DONE: begin
        done_d      = 1'b1;
        busy_d      = 1'b0;
        stop_pend_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      value_q     <= '0;
      words_q     <= '0;
      data_q      <= '0;
      wren_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_pend_q  <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      words_q     <= words_d;
      data_q      <= data_d;
      wren_q      <= wren_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_pend_q  <= err_pend_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign data       = data_q;
  assign wren       = wren_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign words_sent = words_q;

endmodule
